kgp_fetch_decode: RTL and testbench

- Front-end stage of the KGP miniRISC core, upstream of the datapath (CPU_TOP_MODULE).
- Keeps the PC and fetches instruction words from instruction memory over a req/ack handshake.
- Latches each word into an instruction register and decodes it into the registered control word that the datapath consumes.
- Issues one instruction at a time under a valid/ready handshake. Accepts branch redirects from the execute stage.

---
 rtl/kgp_pkg.sv | 67 ++++++
 rtl/kgp_fetch_decode_decoder.sv | 81 ++++++++
 rtl/kgp_fetch_decode.sv | 151 +++++++++++++++
 tb/tb_kgp_fetch_decode.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// -----------------------------------------------------------------------------
// kgp_pkg
// Shared definitions for the KGP miniRISC fetch/decode front end:
//   - opcode and R-type funct encodings
//   - control-word width and bit positions
//   - ALUOp / MemToReg field encodings
//   - fetch/decode FSM state encoding
// Optional build macro: KGP_ILLEGAL_TRAP_EN adds the HALT state.
// -----------------------------------------------------------------------------
package kgp_pkg;

    // Instruction field encodings
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_COMPI = 6'b000010;
    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b000110;
    localparam logic [5:0] OP_SW    = 6'b000111;

    localparam logic [4:0] FN_ADD  = 5'b00001;
    localparam logic [4:0] FN_COMP = 5'b00010;
    localparam logic [4:0] FN_AND  = 5'b00011;
    localparam logic [4:0] FN_XOR  = 5'b00100;

    // Control word layout, MSB first
    localparam int CTRL_W = 23;

    localparam int CTRL_REGWRITE     = 22;
    localparam int CTRL_IMMSEL       = 21;
    localparam int CTRL_ALUSRC       = 20;
    localparam int CTRL_COMPENBL     = 19;
    localparam int CTRL_SHIFTAMNTSEL = 18;
    localparam int CTRL_SHIFTENBL    = 17;
    localparam int CTRL_SHORTBR      = 16;
    localparam int CTRL_LONGBR       = 15;
    localparam int CTRL_MEMREAD      = 14;
    localparam int CTRL_MEMWRITE     = 13;
    localparam int CTRL_BRANCHREG    = 12;
    localparam int CTRL_ALUOP_LO     = 10;  // ALUOp[1:0]      at [11:10]
    localparam int CTRL_REGDST_LO    = 8;   // RegDst[1:0]     at [9:8]
    localparam int CTRL_SHIFTTYPE_LO = 6;   // ShiftType[1:0]  at [7:6]
    localparam int CTRL_BRTYPE_LO    = 4;   // BranchType[1:0] at [5:4]
    localparam int CTRL_JUMPTYPE_LO  = 2;   // JumpType[1:0]   at [3:2]
    localparam int CTRL_MEMTOREG_LO  = 0;   // MemToReg[1:0]   at [1:0]

    // ALUOp encodings
    localparam logic [1:0] ALUOP_NONE = 2'b00;
    localparam logic [1:0] ALUOP_ADD  = 2'b01;
    localparam logic [1:0] ALUOP_AND  = 2'b10;
    localparam logic [1:0] ALUOP_XOR  = 2'b11;

    // MemToReg encodings
    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;

    // Fetch/decode FSM states
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_FLUSH = 3'd3
`ifdef KGP_ILLEGAL_TRAP_EN
        , ST_HALT = 3'd4
`endif
    } fetchState_t;

endpackage

// File: rtl/kgp_fetch_decode_decoder.sv
// -----------------------------------------------------------------------------
// kgp_decoder
// Purely combinational instruction decoder. Takes the opcode (instr[31:26])
// and funct (instr[4:0]) fields and produces the datapath control word plus
// an illegal flag for encodings outside the supported table. Illegal words
// decode to an all-zero control word (NOP).
// Ports:
//   opcode  in  6        instruction opcode field
//   funct   in  5        R-type funct field
//   ctrl    out CTRL_W   decoded control word
//   illegal out 1        opcode/funct not recognised
// -----------------------------------------------------------------------------
module kgp_decoder
    import kgp_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [4:0]        funct,
    output logic [CTRL_W-1:0] ctrl,
    output logic              illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        ctrl    = '0;
        illegal = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin
                        ctrl[CTRL_REGWRITE]              = 1'b1;
                        ctrl[CTRL_ALUOP_LO +: 2]         = ALUOP_ADD;
                    end
                    FN_COMP: begin
                        ctrl[CTRL_REGWRITE]              = 1'b1;
                        ctrl[CTRL_COMPENBL]              = 1'b1;
                        ctrl[CTRL_ALUOP_LO +: 2]         = ALUOP_ADD;
                    end
                    FN_AND: begin
                        ctrl[CTRL_REGWRITE]              = 1'b1;
                        ctrl[CTRL_ALUOP_LO +: 2]         = ALUOP_AND;
                    end
                    FN_XOR: begin
                        ctrl[CTRL_REGWRITE]              = 1'b1;
                        ctrl[CTRL_ALUOP_LO +: 2]         = ALUOP_XOR;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl[CTRL_REGWRITE]                      = 1'b1;
                ctrl[CTRL_ALUSRC]                        = 1'b1;
                ctrl[CTRL_ALUOP_LO +: 2]                 = ALUOP_ADD;
            end
            OP_COMPI: begin
                ctrl[CTRL_REGWRITE]                      = 1'b1;
                ctrl[CTRL_ALUSRC]                        = 1'b1;
                ctrl[CTRL_COMPENBL]                      = 1'b1;
                ctrl[CTRL_ALUOP_LO +: 2]                 = ALUOP_ADD;
            end
            OP_B: begin
                ctrl[CTRL_LONGBR]                        = 1'b1;
            end
            OP_LW: begin
                ctrl[CTRL_REGWRITE]                      = 1'b1;
                ctrl[CTRL_ALUSRC]                        = 1'b1;
                ctrl[CTRL_ALUOP_LO +: 2]                 = ALUOP_ADD;
                ctrl[CTRL_MEMREAD]                       = 1'b1;
                ctrl[CTRL_MEMTOREG_LO +: 2]              = MEMTOREG_MEM;
            end
            OP_SW: begin
                ctrl[CTRL_ALUSRC]                        = 1'b1;
                ctrl[CTRL_ALUOP_LO +: 2]                 = ALUOP_ADD;
                ctrl[CTRL_MEMWRITE]                      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/kgp_fetch_decode.sv
// -----------------------------------------------------------------------------
// kgp_fetch_decode
// Front end of the KGP miniRISC core. Holds the PC, fetches one instruction
// at a time over a req/ack handshake, latches it into the instruction
// register, and issues the registered control word to the datapath under a
// valid/ready handshake. Branch redirects from execute retarget the PC; a
// redirect during an outstanding fetch drains (discards) that fetch's ack.
// Build macro: KGP_ILLEGAL_TRAP_EN -- when defined, an illegal decode parks
// the FSM in HALT (only rst leaves it); otherwise it issues as a NOP with
// illegal=1.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req/addr     fetch request and address (addr = PC)
//   imem_ack/rdata    one-cycle ack pulse with the instruction word
//   ctrl_valid        ctrl/instr/issue_pc/illegal are valid
//   ex_ready          datapath consumes the issued instruction
//   ctrl              registered control word (CTRL_W bits)
//   instr             instruction register
//   issue_pc          PC of the issued instruction
//   redirect/_pc      taken branch and its target
//   illegal           issued word is not in the decode table
// -----------------------------------------------------------------------------
module kgp_fetch_decode
    import kgp_pkg::*;
#(
    parameter int unsigned      PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [PC_W-1:0]  PC_STEP  = PC_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              ctrl_valid,
    input  logic              ex_ready,
    output logic [CTRL_W-1:0] ctrl,
    output logic [31:0]       instr,
    output logic [PC_W-1:0]   issue_pc,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              illegal
);

    fetchState_t       state;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] decCtrl;
    logic              decIllegal;

    // Decode straight off the memory data so the result is registered on the
    // same edge that latches the instruction word.
    kgp_decoder uDecoder (
        .opcode  (imem_rdata[31:26]),
        .funct   (imem_rdata[4:0]),
        .ctrl    (decCtrl),
        .illegal (decIllegal)
    );

    // pc only moves while imem_req is low, so the address is stable for the
    // whole request.
    assign imem_addr = pc;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            ctrl_valid <= 1'b0;
            ctrl       <= '0;
            instr      <= '0;
            issue_pc   <= '0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (redirect) begin
                        // Target parks in pc; an ack in this same cycle is
                        // already drained, otherwise FLUSH waits for it.
                        imem_req <= 1'b0;
                        pc       <= redirect_pc;
                        state    <= imem_ack ? ST_FETCH : ST_FLUSH;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        instr    <= imem_rdata;
                        ctrl     <= decCtrl;
                        illegal  <= decIllegal;
                        issue_pc <= pc;
`ifdef KGP_ILLEGAL_TRAP_EN
                        if (decIllegal) begin
                            state <= ST_HALT;
                        end else begin
                            ctrl_valid <= 1'b1;
                            state      <= ST_ISSUE;
                        end
`else
                        ctrl_valid <= 1'b1;
                        state      <= ST_ISSUE;
`endif
                    end
                end

                ST_ISSUE: begin
                    // Redirect wins over ex_ready: the branch target replaces
                    // the sequential PC outright.
                    if (redirect) begin
                        pc         <= redirect_pc;
                        ctrl_valid <= 1'b0;
                        illegal    <= 1'b0;
                        state      <= ST_FETCH;
                    end else if (ex_ready) begin
                        pc         <= pc + PC_STEP;
                        ctrl_valid <= 1'b0;
                        illegal    <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end

                ST_FLUSH: begin
                    // A newer redirect supersedes the parked target.
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state <= ST_FETCH;
                    end
                end

`ifdef KGP_ILLEGAL_TRAP_EN
                ST_HALT: begin
                    // Parked until rst; redirect and ex_ready are ignored.
                end
`endif

                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_kgp_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_kgp_fetch_decode
// Directed plus randomized checks of the KGP fetch/decode stage against an
// in-bench reference: a table decoder that builds the control word field by
// field and a tracked expected PC. Honors KGP_ILLEGAL_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_kgp_fetch_decode;

    localparam int PC_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              ctrl_valid;
    logic              ex_ready = 1'b0;
    logic [22:0]       ctrl;
    logic [31:0]       instr;
    logic [PC_W-1:0]   issue_pc;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              illegal;

    int checks   = 0;
    int failures = 0;
    logic [31:0] modelPc;

    always #5 clk = ~clk;

    kgp_fetch_decode #(
        .PC_W     (PC_W),
        .RESET_PC (32'h0),
        .PC_STEP  (32'h4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ctrl_valid  (ctrl_valid),
        .ex_ready    (ex_ready),
        .ctrl        (ctrl),
        .instr       (instr),
        .issue_pc    (issue_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: mnemonic table, control word assembled in the
    // documented field order.
    function automatic void refDecode(input logic [31:0] w, output logic [22:0] c,
                                      output logic ill);
        logic       regWrite, aluSrc, compEnbl, longBr, memRead, memWrite;
        logic [1:0] aluOp, memToReg;
        {regWrite, aluSrc, compEnbl, longBr, memRead, memWrite} = '0;
        aluOp    = 2'd0;
        memToReg = 2'd0;
        ill      = 1'b0;
        case (w[31:26])
            6'd0: begin
                case (w[4:0])
                    5'd1: begin regWrite = 1; aluOp = 2'd1; end                // add
                    5'd2: begin regWrite = 1; compEnbl = 1; aluOp = 2'd1; end  // comp
                    5'd3: begin regWrite = 1; aluOp = 2'd2; end                // and
                    5'd4: begin regWrite = 1; aluOp = 2'd3; end                // xor
                    default: ill = 1'b1;
                endcase
            end
            6'd1: begin regWrite = 1; aluSrc = 1; aluOp = 2'd1; end            // addi
            6'd2: begin regWrite = 1; aluSrc = 1; compEnbl = 1; aluOp = 2'd1; end // compi
            6'd5: begin longBr = 1; end                                        // b
            6'd6: begin regWrite = 1; aluSrc = 1; aluOp = 2'd1; memRead = 1;
                        memToReg = 2'd1; end                                   // lw
            6'd7: begin aluSrc = 1; aluOp = 2'd1; memWrite = 1; end            // sw
            default: ill = 1'b1;
        endcase
        c = {regWrite, 1'b0, aluSrc, compEnbl, 1'b0, 1'b0, 1'b0, longBr, memRead,
             memWrite, 1'b0, aluOp, 2'b00, 2'b00, 2'b00, 2'b00, memToReg};
    endfunction

    // k 0..3: add/comp/and/xor, 4..8: addi/compi/b/lw/sw, 9/10: illegal.
    function automatic logic [31:0] mkWord(input int k);
        logic [31:0] w;
        w = $urandom();
        case (k)
            0, 1, 2, 3: begin w[31:26] = 6'd0; w[4:0] = 5'(k + 1); end
            4: w[31:26] = 6'd1;
            5: w[31:26] = 6'd2;
            6: w[31:26] = 6'd5;
            7: w[31:26] = 6'd6;
            8: w[31:26] = 6'd7;
            9: w[31:26] = 6'($urandom_range(8, 63));
            default: begin w[31:26] = 6'd0; w[4:0] = 5'($urandom_range(5, 31)); end
        endcase
        return w;
    endfunction

    // Wait (bounded) for a request and check its address.
    task automatic waitReq(input logic [31:0] expAddr, input string tag);
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            check({tag, "_no_valid_while_fetching"}, 64'(ctrl_valid), 64'd0);
            step();
            n++;
        end
        check({tag, "_req"}, 64'(imem_req), 64'd1);
        check({tag, "_addr"}, 64'(imem_addr), 64'(expAddr));
    endtask

    // Answer the pending request after ackDelay cycles, then check the issue.
    task automatic fetchIssue(input logic [31:0] word, input int ackDelay, input string tag);
        logic [22:0] expCtrl;
        logic        expIll;
        for (int i = 0; i < ackDelay; i++) begin
            step();
            check({tag, "_req_held"}, 64'(imem_req), 64'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        refDecode(word, expCtrl, expIll);
`ifdef KGP_ILLEGAL_TRAP_EN
        if (expIll) begin
            check({tag, "_halt_valid"}, 64'(ctrl_valid), 64'd0);
            check({tag, "_halt_illegal"}, 64'(illegal), 64'd1);
            check({tag, "_halt_req"}, 64'(imem_req), 64'd0);
            return;
        end
`endif
        check({tag, "_valid"}, 64'(ctrl_valid), 64'd1);
        check({tag, "_ctrl"}, 64'(ctrl), 64'(expCtrl));
        check({tag, "_instr"}, 64'(instr), 64'(word));
        check({tag, "_issue_pc"}, 64'(issue_pc), 64'(modelPc));
        check({tag, "_illegal"}, 64'(illegal), 64'(expIll));
        check({tag, "_req_dropped"}, 64'(imem_req), 64'd0);
    endtask

    task automatic consume(input string tag);
        ex_ready = 1'b1;
        step();
        ex_ready = 1'b0;
        modelPc  = modelPc + 32'd4;
        check({tag, "_valid_cleared"}, 64'(ctrl_valid), 64'd0);
    endtask

    initial begin : stimulus
        logic [31:0] word;
        logic [22:0] expCtrl;
        logic        expIll;
        int          kind;
        int          stall;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(ctrl_valid), 64'd0);
        check("rst_ctrl", 64'(ctrl), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_issue_pc", 64'(issue_pc), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        rst     = 1'b0;
        modelPc = 32'h0;

        // addi at 0, ack two cycles after the request
        waitReq(32'h0, "addi");
        fetchIssue(32'h0400_0005, 2, "addi");
        check("addi_ctrl_literal", 64'(ctrl), 64'h50_0400);
        consume("addi");
        waitReq(32'h4, "addi_next");

        // Reset mid-handshake; a late ack in the following cycle is ignored
        rst = 1'b1;
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0400_0005;
        step();
        imem_ack   = 1'b0;
        check("late_ack_valid", 64'(ctrl_valid), 64'd0);
        check("late_ack_req", 64'(imem_req), 64'd1);
        check("late_ack_addr", 64'(imem_addr), 64'd0);
        modelPc = 32'h0;

        // add / comp / and / xor at 0, 4, 8, 12; stall the xor for 5 cycles
        for (int i = 0; i < 4; i++) begin
            word = mkWord(i);
            fetchIssue(word, 1, "rtype");
            if (i == 3) begin
                refDecode(word, expCtrl, expIll);
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("stall_valid", 64'(ctrl_valid), 64'd1);
                    check("stall_ctrl", 64'(ctrl), 64'(expCtrl));
                    check("stall_instr", 64'(instr), 64'(word));
                    check("stall_issue_pc", 64'(issue_pc), 64'd12);
                    check("stall_no_req", 64'(imem_req), 64'd0);
                end
            end
            consume("rtype");
            waitReq(modelPc, "rtype_next");
        end

        // Redirect to 0x40 while waiting; ack arrives 3 cycles later and is dropped
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check("flush_req_dropped", 64'(imem_req), 64'd0);
        step();
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1400_0007;
        step();
        imem_ack = 1'b0;
        check("flush_no_valid", 64'(ctrl_valid), 64'd0);
        modelPc = 32'h40;
        waitReq(32'h40, "flush_next");
        fetchIssue(mkWord(7), 0, "after_flush");
        consume("after_flush");

        // Redirect and ack in the same WAIT cycle
        waitReq(32'h44, "same_cycle");
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        imem_ack    = 1'b1;
        imem_rdata  = mkWord(4);
        step();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("same_cycle_valid", 64'(ctrl_valid), 64'd0);
        check("same_cycle_req", 64'(imem_req), 64'd0);
        modelPc = 32'h80;
        waitReq(32'h80, "same_cycle_next");

        // Redirect while in FETCH
        fetchIssue(mkWord(8), 1, "fetch_redir");
        consume("fetch_redir");
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        check("fetch_redir_req", 64'(imem_req), 64'd0);
        modelPc = 32'h200;
        waitReq(32'h200, "fetch_redir_next");

        // Redirect and ex_ready together in ISSUE at pc=8
        rst = 1'b1;
        step();
        rst     = 1'b0;
        modelPc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            waitReq(modelPc, "prio_pre");
            fetchIssue(mkWord(i + 4), 1, "prio_pre");
            consume("prio_pre");
        end
        waitReq(32'h8, "prio");
        fetchIssue(mkWord(5), 2, "prio");
        ex_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        ex_ready = 1'b0;
        redirect = 1'b0;
        check("prio_valid", 64'(ctrl_valid), 64'd0);
        modelPc = 32'h100;
        waitReq(32'h100, "prio_next");

        // PC wrap at the top of the address space
        fetchIssue(mkWord(6), 0, "wrap_pre");
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        modelPc  = 32'hFFFF_FFFC;
        waitReq(32'hFFFF_FFFC, "wrap");
        fetchIssue(mkWord(0), 1, "wrap");
        consume("wrap");
        waitReq(32'h0, "wrap_next");

        // Randomized stream against the reference
        for (int n = 0; n < 24; n++) begin
`ifdef KGP_ILLEGAL_TRAP_EN
            kind = int'($urandom_range(0, 8));
`else
            kind = int'($urandom_range(0, 10));
`endif
            word  = mkWord(kind);
            fetchIssue(word, int'($urandom_range(0, 3)), "rand");
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                step();
                check("rand_stall_valid", 64'(ctrl_valid), 64'd1);
                check("rand_stall_instr", 64'(instr), 64'(word));
            end
            consume("rand");
            waitReq(modelPc, "rand_next");
        end

        // Opcode 111111
        word = 32'hFC00_0000 | (32'($urandom()) & 32'h03FF_FFFF);
        fetchIssue(word, 1, "illegal");
`ifdef KGP_ILLEGAL_TRAP_EN
        ex_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        for (int s = 0; s < 10; s++) begin
            step();
            check("halt_no_req", 64'(imem_req), 64'd0);
            check("halt_no_valid", 64'(ctrl_valid), 64'd0);
            check("halt_illegal", 64'(illegal), 64'd1);
        end
        ex_ready = 1'b0;
        redirect = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("halt_rst_illegal", 64'(illegal), 64'd0);
        modelPc = 32'h0;
        waitReq(32'h0, "halt_exit");
`else
        for (int s = 0; s < 3; s++) begin
            step();
            check("illegal_hold_flag", 64'(illegal), 64'd1);
            check("illegal_hold_ctrl", 64'(ctrl), 64'd0);
            check("illegal_hold_valid", 64'(ctrl_valid), 64'd1);
        end
        consume("illegal");
        waitReq(modelPc, "illegal_next");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
